// File: rtl/remote_code_transmitter_if.sv
// Handshake and output bundle of the IR remote-code transmitter.
// The master side issues requests; the slave side (the transmitter) returns status, code and IR envelope.
interface remote_code_transmitter_if;
  logic        start;
  logic [3:0]  digit;
  logic        busy;
  logic        done;
  logic        invalid;
  logic [11:0] code_out;
  logic        ir_out;

  modport master (
    output start, digit,
    input  busy, done, invalid, code_out, ir_out
  );

  modport slave (
    input  start, digit,
    output busy, done, invalid, code_out, ir_out
  );
endinterface

// File: rtl/remote_code_transmitter.sv
// Maps a decimal digit to its 12-bit remote key code and sends it as repeated pulse-width IR frames.
// Optional carrier modulation of ir_out is enabled by defining IR_CARRIER_EN.
module remote_code_transmitter #(
  parameter int unsigned TICKS_PER_UNIT     = 60000,
  parameter int unsigned FRAME_REPEATS      = 3,
  parameter int unsigned FRAME_PERIOD_UNITS = 75,
  parameter int unsigned CARRIER_DIV        = 1250
) (
  input  logic                       clk,
  input  logic                       rst,
  remote_code_transmitter_if.slave   bus
);

  localparam int unsigned TICK_W = $clog2(TICKS_PER_UNIT);
  localparam int unsigned UNIT_W = $clog2(FRAME_PERIOD_UNITS);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(FRAME_PERIOD_UNITS - 1);
  localparam logic [3:0]        REP_LAST  = 4'(FRAME_REPEATS - 1);

  if (TICKS_PER_UNIT < 2) begin : g_bad_ticks
    $error("TICKS_PER_UNIT must be at least 2");
  end
  if (FRAME_REPEATS < 1 || FRAME_REPEATS > 15) begin : g_bad_repeats
    $error("FRAME_REPEATS must be within 1..15");
  end
  if (FRAME_PERIOD_UNITS < 40) begin : g_bad_period
    $error("FRAME_PERIOD_UNITS must be at least 40");
  end
  if (CARRIER_DIV < 1) begin : g_bad_div
    $error("CARRIER_DIV must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    HDR_MARK,
    BIT_SPACE,
    BIT_MARK,
    GAP
  } state_t;

  state_t              state;
  logic [TICK_W-1:0]   tick;
  logic [UNIT_W-1:0]   unit_cnt;
  logic [2:0]          seg_cnt;   // units left in the current mark
  logic [3:0]          bit_idx;
  logic [3:0]          rep_cnt;   // frames already completed in this burst
  logic [11:0]         code_q;
  logic                busy_q;
  logic                done_q;
  logic                invalid_q;
  logic                env_q;

  logic unit_end;
  logic frame_end;

  function automatic logic [11:0] encode(input logic [3:0] d);
    logic [11:0] c;
    unique case (d)
      4'd0:    c = 12'h910;
      4'd1:    c = 12'h010;
      4'd2:    c = 12'h810;
      4'd3:    c = 12'h410;
      4'd4:    c = 12'hC10;
      4'd5:    c = 12'h210;
      4'd6:    c = 12'hA10;
      4'd7:    c = 12'h610;
      4'd8:    c = 12'hE10;
      4'd9:    c = 12'h110;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  assign unit_end  = (tick == TICK_LAST);
  // The frame boundary takes priority over any segment: it normally ends GAP, but when a
  // 40U frame fills a 40U period it ends bit 0's mark directly, so no cycle is ever added.
  assign frame_end = unit_end && (unit_cnt == UNIT_LAST);

  // NOTE: every register here is state, so only non-blocking assignments are used; a blocking
  // assignment would let later statements in this block see the new value within the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      unit_cnt  <= '0;
      seg_cnt   <= '0;
      bit_idx   <= '0;
      rep_cnt   <= '0;
      code_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      env_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          if (bus.digit <= 4'd9) begin
            code_q   <= encode(bus.digit);
            busy_q   <= 1'b1;
            state    <= HDR_MARK;
            env_q    <= 1'b1;
            tick     <= '0;
            unit_cnt <= '0;
            seg_cnt  <= 3'd4;
            bit_idx  <= 4'd11;
            rep_cnt  <= '0;
          end else begin
            invalid_q <= 1'b1;
          end
        end
      end else begin
        tick <= unit_end ? '0 : tick + 1'b1;
        if (unit_end) begin
          unit_cnt <= frame_end ? '0 : unit_cnt + 1'b1;
          if (frame_end) begin
            if (rep_cnt == REP_LAST) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              env_q  <= 1'b0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
              state   <= HDR_MARK;
              seg_cnt <= 3'd4;
              bit_idx <= 4'd11;
              env_q   <= 1'b1;
            end
          end else begin
            unique case (state)
              HDR_MARK: begin
                if (seg_cnt == 3'd1) begin
                  state <= BIT_SPACE;
                  env_q <= 1'b0;
                end else begin
                  seg_cnt <= seg_cnt - 3'd1;
                end
              end
              BIT_SPACE: begin
                state   <= BIT_MARK;
                seg_cnt <= code_q[bit_idx] ? 3'd2 : 3'd1;
                env_q   <= 1'b1;
              end
              BIT_MARK: begin
                if (seg_cnt == 3'd1) begin
                  env_q <= 1'b0;
                  if (bit_idx == 4'd0) begin
                    state <= GAP;
                  end else begin
                    bit_idx <= bit_idx - 4'd1;
                    state   <= BIT_SPACE;
                  end
                end else begin
                  seg_cnt <= seg_cnt - 3'd1;
                end
              end
              GAP:     ;
              default: state <= IDLE;
            endcase
          end
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.invalid  = invalid_q;
  assign bus.code_out = code_q;

`ifdef IR_CARRIER_EN
  localparam int unsigned DIV_W = $clog2(CARRIER_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CARRIER_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             phase;    // 0 = high half of the carrier

  // Held at phase 0 whenever the envelope is low so each mark starts on a high half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!env_q) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign bus.ir_out = env_q & ~phase;
`else
  assign bus.ir_out = env_q;
`endif

endmodule

// File: tb/tb_remote_code_transmitter.sv
// Directed self-checking bench for remote_code_transmitter (4 clocks per unit, 3 frames of 75 units).
module tb_remote_code_transmitter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  remote_code_transmitter_if bus ();

  remote_code_transmitter #(
    .TICKS_PER_UNIT     (4),
    .FRAME_REPEATS      (3),
    .FRAME_PERIOD_UNITS (75),
    .CARRIER_DIV        (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected envelope c cycles into a frame: 16-cycle header, then per bit a 4-cycle space and
  // an 8-cycle (bit=1) or 4-cycle (bit=0) mark, MSB first; low for the rest of the 300-cycle frame.
  function automatic logic exp_env(input logic [11:0] code, input int c);
    int t;
    int w;
    if (c < 16) return 1'b1;
    t = 16;
    for (int b = 11; b >= 0; b--) begin
      if (c < t + 4) return 1'b0;
      t += 4;
      w = code[b] ? 8 : 4;
      if (c < t + w) return 1'b1;
      t += w;
    end
    return 1'b0;
  endfunction

  // Called on a falling edge while idle; returns on the falling edge of cycle 1 (first busy cycle).
  task automatic send(input logic [3:0] d);
    bus.start = 1'b1;
    bus.digit = d;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Checks all three frames cycle by cycle from cycle 1, optionally injecting a start at cycle inj,
  // and always raising start during the last busy cycle, which must be ignored.
  task automatic check_frames(input logic [11:0] code, input int inj, input logic [3:0] inj_d);
    for (int k = 1; k <= 900; k++) begin
      check("ir_out", 12'(bus.ir_out), 12'(exp_env(code, (k - 1) % 300)));
      check("busy", 12'(bus.busy), 12'd1);
      if (inj > 0 && k == inj + 1) begin
        check("invalid_while_busy", 12'(bus.invalid), 12'd0);
        check("code_kept", bus.code_out, code);
      end
      if (k == inj) begin
        bus.start = 1'b1;
        bus.digit = inj_d;
      end else if (k == 900) begin
        bus.start = 1'b1;
        bus.digit = 4'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_pulse", 12'(bus.done), 12'd1);
    check("busy_at_done", 12'(bus.busy), 12'd0);
    check("ir_at_done", 12'(bus.ir_out), 12'd0);
    check("code_after_done", bus.code_out, code);
    @(negedge clk);
    check("done_one_cycle", 12'(bus.done), 12'd0);
    check("start_on_done_ignored", 12'(bus.busy), 12'd0);
  endtask

  int widths[13];
  int exp_widths[13];
  int run_len;
  int n_marks;

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.digit     = 4'd0;
    exp_widths    = '{16, 8, 4, 4, 8, 4, 4, 4, 8, 4, 4, 4, 4};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 12'(bus.busy), 12'd0);
    check("rst_done", 12'(bus.done), 12'd0);
    check("rst_invalid", 12'(bus.invalid), 12'd0);
    check("rst_code", bus.code_out, 12'h000);
    check("rst_ir", 12'(bus.ir_out), 12'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 12'(bus.busy), 12'd0);

    // Digit 1: full waveform, three frames, done at cycle 901
    send(4'd1);
    check("code_d1", bus.code_out, 12'h010);
    check_frames(12'h010, 0, 4'd0);

    // Digit 0: mark widths of the first frame
    send(4'd0);
    check("code_d0", bus.code_out, 12'h910);
    run_len = 0;
    n_marks = 0;
    for (int k = 1; k <= 300; k++) begin
      if (bus.ir_out === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        if (n_marks < 13) widths[n_marks] = run_len;
        n_marks++;
        run_len = 0;
      end
      @(negedge clk);
    end
    check("d0_mark_count", 12'(n_marks), 12'd13);
    for (int i = 0; i < 13; i++) check("d0_mark_width", 12'(widths[i]), 12'(exp_widths[i]));
    repeat (600) @(negedge clk);
    check("d0_done", 12'(bus.done), 12'd1);
    check("d0_busy_low", 12'(bus.busy), 12'd0);

    // Digit 10 while idle: invalid pulse only
    @(negedge clk);
    bus.start = 1'b1;
    bus.digit = 4'hA;
    @(negedge clk);
    bus.start = 1'b0;
    check("invalid_pulse", 12'(bus.invalid), 12'd1);
    check("invalid_busy", 12'(bus.busy), 12'd0);
    check("invalid_ir", 12'(bus.ir_out), 12'd0);
    check("invalid_code", bus.code_out, 12'h910);
    @(negedge clk);
    check("invalid_one_cycle", 12'(bus.invalid), 12'd0);
    check("invalid_still_idle", 12'(bus.busy), 12'd0);

    // Digit 5 with a digit 9 request at cycle 50 that must be ignored
    send(4'd5);
    check("code_d5", bus.code_out, 12'h210);
    check_frames(12'h210, 50, 4'd9);

    // Digit 2 interrupted by reset at cycle 120 inside bit 0's mark
    send(4'd2);
    repeat (119) @(negedge clk);
    check("pre_rst_mark", 12'(bus.ir_out), 12'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_ir", 12'(bus.ir_out), 12'd0);
    check("async_rst_busy", 12'(bus.busy), 12'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_code_cleared", bus.code_out, 12'h000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_done_after_rst", 12'(bus.done), 12'd0);
    end

    // Digit 7 after the abandoned frame
    send(4'd7);
    check("code_d7", bus.code_out, 12'h610);
    check_frames(12'h610, 0, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
